// File: rtl/alu_pkg.sv
// Shared constants, bus layout and FSM encoding for the ALU writeback stage.
package alu_pkg;

  localparam int unsigned SLOT_COUNT = 13;
  localparam int unsigned SLOT_W     = 16;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned COUNT_W    = 16;
  localparam int unsigned HI_LSB     = SLOT_COUNT * SLOT_W;
  localparam int unsigned BUS_W      = HI_LSB + SLOT_W;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 6'd3;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_OR   = 6'd5;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 6'd6;
  localparam logic [OPCODE_W-1:0] OP_NAND = 6'd7;
  localparam logic [OPCODE_W-1:0] OP_NOR  = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_XNOR = 6'd9;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 6'd10;
  localparam logic [OPCODE_W-1:0] OP_LSL  = 6'd11;
  localparam logic [OPCODE_W-1:0] OP_LSR  = 6'd12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR_LO = 2'd1;
  localparam logic [1:0] ST_WR_HI = 2'd2;

  // State held across the write cycles; the low word and its address live in the output registers.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   rdst2;
    logic [SLOT_W-1:0]   hi;
  } wb_hold_t;

endpackage

// File: rtl/wb_slot_select.sv
// Combinational opcode decode: picks the result slot, the MUL high word and the legal flag.
module wb_slot_select
  import alu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [BUS_W-1:0]    alu_bus,
  output logic [SLOT_W-1:0]   slot_c,
  output logic [SLOT_W-1:0]   hi_c,
  output logic                legal_c
);

  always_comb begin
    slot_c = '0;
    for (int unsigned i = 0; i < SLOT_COUNT; i++) begin
      if (opcode == OPCODE_W'(i)) slot_c = alu_bus[i*SLOT_W +: SLOT_W];
    end
  end

  always_comb begin
    legal_c = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_NEG, OP_MUL, OP_DIV, OP_OR, OP_XOR,
      OP_NAND, OP_NOR, OP_XNOR, OP_NOT, OP_LSL, OP_LSR: legal_c = 1'b1;
      default: legal_c = 1'b0;
    endcase
  end

  assign hi_c = alu_bus[HI_LSB +: SLOT_W];

endmodule

// File: rtl/alu_writeback.sv
// Writeback FSM: captures one ALU result per transfer and writes one (or two, for MUL) memory words.
module alu_writeback
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [ADDR_W-1:0]   rdst1,
  input  logic [ADDR_W-1:0]   rdst2,
  input  logic [BUS_W-1:0]    alu_bus,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SLOT_W-1:0]   mem_wdata,
  output logic                done,
  output logic                err,
  output logic [COUNT_W-1:0]  wr_count
);

  logic [1:0]        state, state_d;
  wb_hold_t          hold, hold_d;
  logic              in_ready_d, mem_we_d, done_d, err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [SLOT_W-1:0] mem_wdata_d;
  logic [SLOT_W-1:0] slot_c, hi_c;
  logic              legal_c;

  wb_slot_select u_slot (
    .opcode  (opcode),
    .alu_bus (alu_bus),
    .slot_c  (slot_c),
    .hi_c    (hi_c),
    .legal_c (legal_c)
  );

  // Output registers are loaded with the values for the state being entered.
  always_comb begin
    state_d     = state;
    hold_d      = hold;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (legal_c) begin
            hold_d.opcode = opcode;
            hold_d.rdst2  = rdst2;
            hold_d.hi     = hi_c;
            state_d       = ST_WR_LO;
            mem_we_d      = 1'b1;
            mem_addr_d    = rdst1;
            mem_wdata_d   = slot_c;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WR_LO: begin
        if (hold.opcode == OP_MUL) begin
          state_d     = ST_WR_HI;
          mem_we_d    = 1'b1;
          mem_addr_d  = hold.rdst2;
          mem_wdata_d = hold.hi;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_WR_HI: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      wr_count  <= '0;
    end else begin
      state     <= state_d;
      hold      <= hold_d;
      in_ready  <= in_ready_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      done      <= done_d;
      err       <= err_d;
      wr_count  <= wr_count + COUNT_W'(mem_we);
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: stimulus queues expected events, a monitor pops and compares.
module tb_alu_writeback;
  import alu_pkg::*;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready;
  logic [5:0]       opcode, rdst1, rdst2;
  logic [BUS_W-1:0] alu_bus;
  logic             mem_we, done, err;
  logic [5:0]       mem_addr;
  logic [15:0]      mem_wdata, wr_count;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rdst1(rdst1), .rdst2(rdst2), .alu_bus(alu_bus),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .err(err), .wr_count(wr_count)
  );

  typedef struct {
    int          kind;  // 0 write, 1 done, 2 err
    logic [5:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] exp_count;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [5:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind, input logic [5:0] a, input logic [15:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none (cycle %0d)",
               kind, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (kind == 0) begin
        chk("mem_addr", 32'(a), 32'(e.addr));
        chk("mem_wdata", 32'(d), 32'(e.data));
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mem_we) check_event(0, mem_addr, mem_wdata);
      else chk("idle_bus_zero", {10'd0, mem_addr, mem_wdata}, 32'd0);
      if (done) check_event(1, 6'd0, 16'd0);
      if (err) check_event(2, 6'd0, 16'd0);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [5:0] r1, input logic [5:0] r2,
                       input logic [15:0] lo, input logic [15:0] hi,
                       input bit keep, input bit exp_done, output int acc_cyc);
    int n;
    logic [BUS_W-1:0] bus;
    bus = '0;
    for (int i = 0; i < 13; i++) bus[i*16 +: 16] = 16'(32'hA000 + i * 32'h0111);
    bus[HI_LSB +: 16] = hi;
    if (op < 6'd13) bus[int'(op)*16 +: 16] = lo;
    opcode = op; rdst1 = r1; rdst2 = r2; alu_bus = bus; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", n);
    end else if (op < 6'd13) begin
      push(0, r1, lo); exp_count++;
      if (op == OP_MUL) begin push(0, r2, hi); exp_count++; end
      if (exp_done) push(1, 6'd0, 16'd0);
    end else begin
      push(2, 6'd0, 16'd0);
    end
    @(negedge clk);
    if (!keep) begin
      in_valid = 1'b0;
      opcode = 6'($urandom); rdst1 = 6'($urandom); rdst2 = 6'($urandom);
      alu_bus = {7{$urandom}};
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("wr_count", 32'(wr_count), 32'(exp_count));
  endtask

  initial begin
    int a1, a2, a3;
    reset = 1'b1; in_valid = 1'b0; opcode = '0; rdst1 = '0; rdst2 = '0; alu_bus = '0;
    exp_count = 16'd0;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // ADD: write one cycle after accept, done the cycle after that
    issue(OP_ADD, 6'd5, 6'd0, 16'h1234, 16'h0000, 0, 1, a1);
    chk("add_latency_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    chk("add_done", 32'(done), 32'd1);
    chk("add_ready_back", 32'(in_ready), 32'd1);
    drain();

    // MUL: two writes on consecutive cycles, distinct and identical destinations
    issue(OP_MUL, 6'd2, 6'd3, 16'h5678, 16'h0009, 0, 1, a1);
    chk("mul_latency_we", 32'(mem_we), 32'd1);
    drain();
    issue(OP_MUL, 6'd7, 6'd7, 16'hBEEF, 16'hCAFE, 0, 1, a1);
    drain();

    // Illegal opcodes at the top and at the first illegal value
    issue(6'h3F, 6'd9, 6'd9, 16'h1111, 16'h2222, 0, 0, a1);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_ready", 32'(in_ready), 32'd1);
    chk("illegal_no_we", 32'(mem_we), 32'd0);
    drain();
    issue(6'd13, 6'd9, 6'd9, 16'h1111, 16'h2222, 0, 0, a1);
    drain();

    // Assorted single-word ops including the last legal slot
    issue(OP_SUB, 6'd10, 6'd0, 16'h0F0F, 16'h0000, 0, 1, a1);
    issue(OP_NOT, 6'd63, 6'd1, 16'hFFFF, 16'h5555, 0, 1, a1);
    issue(OP_LSR, 6'd0, 6'd0, 16'h8001, 16'h0000, 0, 1, a1);
    drain();

    // Back-to-back DIV with in_valid held and inputs changing during writes
    issue(OP_DIV, 6'd20, 6'd0, 16'hD001, 16'h0000, 1, 1, a1);
    issue(OP_DIV, 6'd21, 6'd0, 16'hD002, 16'h0000, 1, 1, a2);
    issue(OP_DIV, 6'd22, 6'd0, 16'hD003, 16'h0000, 0, 1, a3);
    chk("b2b_spacing_1", 32'(a2 - a1), 32'd2);
    chk("b2b_spacing_2", 32'(a3 - a2), 32'd2);
    drain();

    // Reset during WR_HI of a MUL aborts the done pulse
    issue(OP_MUL, 6'd30, 6'd31, 16'hAAAA, 16'hBBBB, 0, 0, a1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wr_count", 32'(wr_count), 32'd0);
    chk("abort_ready_in_reset", 32'(in_ready), 32'd0);
    exp_count = 16'd0;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(in_ready), 32'd1);
    drain();

    // Reset wins over a simultaneous transfer
    opcode = OP_ADD; rdst1 = 6'd12; alu_bus = '0; alu_bus[15:0] = 16'h7777; in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_priority_no_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("rst_priority_ready", 32'(in_ready), 32'd1);
    drain();

    // Counter wrap from 0xFFFF
    force dut.wr_count = 16'hFFFF;
    #1;
    release dut.wr_count;
    #1;
    chk("wrap_preload", 32'(wr_count), 32'h0000FFFF);
    exp_count = 16'hFFFF;
    @(negedge clk);
    issue(OP_ADD, 6'd1, 6'd0, 16'h4242, 16'h0000, 0, 1, a1);
    drain();
    chk("wrap_zero", 32'(wr_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
